// File: rtl/rob_module.sv
// Reorder buffer: takes renamed instructions from the regfile, resolves their operands against
// completed entries, issues them to the reservation stations and commits results in program order.
module rob_module #(
    parameter int ROB_DEPTH    = 16,
    parameter int ROB_IDX_SIZE = 4,
    parameter int GPR_SIZE     = 64,
    parameter int GPR_IDX_SIZE = 5
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_reg_done,
    input  logic [GPR_IDX_SIZE-1:0] in_reg_dst,
    input  logic                    in_reg_set_nzcv,
    input  logic                    in_reg_uses_nzcv,
    input  logic                    in_reg_mispredict,
    input  logic                    in_reg_src1_valid,
    input  logic [ROB_IDX_SIZE-1:0] in_reg_src1_rob_index,
    input  logic [GPR_SIZE-1:0]     in_reg_src1_value,
    input  logic                    in_reg_src2_valid,
    input  logic [ROB_IDX_SIZE-1:0] in_reg_src2_rob_index,
    input  logic [GPR_SIZE-1:0]     in_reg_src2_value,
    input  logic                    in_reg_nzcv_valid,
    input  logic [ROB_IDX_SIZE-1:0] in_reg_nzcv_rob_index,
    input  logic [3:0]              in_reg_nzcv,
    input  logic [2:0]              in_reg_fu_id,
    input  logic [3:0]              in_reg_fu_op,
    input  logic [3:0]              in_reg_cond_codes,
    output logic [ROB_IDX_SIZE-1:0] out_reg_next_rob_index,
    output logic                    out_full,
    input  logic                    in_fu_done,
    input  logic [ROB_IDX_SIZE-1:0] in_fu_rob_index,
    input  logic [GPR_SIZE-1:0]     in_fu_value,
    input  logic [3:0]              in_fu_nzcv,
    output logic                    out_rs_done,
    output logic                    out_rs_src1_valid,
    output logic [GPR_SIZE-1:0]     out_rs_src1_value,
    output logic [ROB_IDX_SIZE-1:0] out_rs_src1_rob_index,
    output logic                    out_rs_src2_valid,
    output logic [GPR_SIZE-1:0]     out_rs_src2_value,
    output logic [ROB_IDX_SIZE-1:0] out_rs_src2_rob_index,
    output logic                    out_rs_nzcv_valid,
    output logic [3:0]              out_rs_nzcv,
    output logic [ROB_IDX_SIZE-1:0] out_rs_nzcv_rob_index,
    output logic [ROB_IDX_SIZE-1:0] out_rs_rob_index,
    output logic [2:0]              out_rs_fu_id,
    output logic [3:0]              out_rs_fu_op,
    output logic [3:0]              out_rs_cond_codes,
    output logic                    out_rs_set_nzcv,
    output logic                    out_rs_uses_nzcv,
    output logic                    out_reg_should_commit,
    output logic [GPR_IDX_SIZE-1:0] out_reg_reg_index,
    output logic [GPR_SIZE-1:0]     out_reg_commit_value,
    output logic [ROB_IDX_SIZE-1:0] out_reg_commit_rob_index,
    output logic                    out_reg_set_nzcv,
    output logic [3:0]              out_reg_nzcv,
    output logic                    out_flush
);
    localparam int CW = ROB_IDX_SIZE + 1;

    logic [ROB_IDX_SIZE-1:0] r_head, r_tail;
    logic [CW-1:0]           r_count;
    logic                    r_valid      [ROB_DEPTH];
    logic                    r_done       [ROB_DEPTH];
    logic                    r_set_nzcv   [ROB_DEPTH];
    logic                    r_mispredict [ROB_DEPTH];
    logic [GPR_IDX_SIZE-1:0] r_dst        [ROB_DEPTH];
    logic [GPR_SIZE-1:0]     r_value      [ROB_DEPTH];
    logic [3:0]              r_nzcv       [ROB_DEPTH];

    logic                    w_full, w_dispatch, w_commit, w_flush;
    logic [GPR_SIZE:0]       w_src1, w_src2;
    logic [4:0]              w_nzcv;

    // Priority: architectural value, then same-cycle FU broadcast, then a completed entry.
    function automatic logic [GPR_SIZE:0] resolve(input logic reg_valid, input logic [GPR_SIZE-1:0] reg_val,
                                                  input logic fu_hit, input logic [GPR_SIZE-1:0] fu_val,
                                                  input logic ent_done, input logic [GPR_SIZE-1:0] ent_val);
        if (reg_valid)     return {1'b1, reg_val};
        else if (fu_hit)   return {1'b1, fu_val};
        else if (ent_done) return {1'b1, ent_val};
        else               return '0;
    endfunction

    function automatic logic [4:0] resolve4(input logic reg_valid, input logic [3:0] reg_val,
                                            input logic fu_hit, input logic [3:0] fu_val,
                                            input logic ent_done, input logic [3:0] ent_val);
        if (reg_valid)     return {1'b1, reg_val};
        else if (fu_hit)   return {1'b1, fu_val};
        else if (ent_done) return {1'b1, ent_val};
        else               return '0;
    endfunction

    assign w_full                 = (r_count == CW'(ROB_DEPTH));
    assign out_full               = w_full;
    assign out_reg_next_rob_index = r_tail;
    assign w_dispatch             = in_reg_done & ~w_full;
    assign w_commit               = (r_count != '0) & r_done[r_head];
    assign w_flush                = w_commit & r_mispredict[r_head];

    assign w_src1 = resolve(in_reg_src1_valid, in_reg_src1_value,
                            in_fu_done && (in_fu_rob_index == in_reg_src1_rob_index), in_fu_value,
                            r_done[in_reg_src1_rob_index], r_value[in_reg_src1_rob_index]);
    assign w_src2 = resolve(in_reg_src2_valid, in_reg_src2_value,
                            in_fu_done && (in_fu_rob_index == in_reg_src2_rob_index), in_fu_value,
                            r_done[in_reg_src2_rob_index], r_value[in_reg_src2_rob_index]);
    assign w_nzcv = resolve4(in_reg_nzcv_valid, in_reg_nzcv,
                             in_fu_done && (in_fu_rob_index == in_reg_nzcv_rob_index), in_fu_nzcv,
                             r_done[in_reg_nzcv_rob_index], r_nzcv[in_reg_nzcv_rob_index]);

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_count <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_done[i] <= 1'b0;
                r_set_nzcv[i] <= 1'b0;
                r_mispredict[i] <= 1'b0;
                r_dst[i] <= '0;
                r_value[i] <= '0;
                r_nzcv[i] <= '0;
            end
            out_rs_done <= 1'b0;
            out_rs_src1_valid <= 1'b0;
            out_rs_src1_value <= '0;
            out_rs_src1_rob_index <= '0;
            out_rs_src2_valid <= 1'b0;
            out_rs_src2_value <= '0;
            out_rs_src2_rob_index <= '0;
            out_rs_nzcv_valid <= 1'b0;
            out_rs_nzcv <= '0;
            out_rs_nzcv_rob_index <= '0;
            out_rs_rob_index <= '0;
            out_rs_fu_id <= '0;
            out_rs_fu_op <= '0;
            out_rs_cond_codes <= '0;
            out_rs_set_nzcv <= 1'b0;
            out_rs_uses_nzcv <= 1'b0;
            out_reg_should_commit <= 1'b0;
            out_reg_reg_index <= '0;
            out_reg_commit_value <= '0;
            out_reg_commit_rob_index <= '0;
            out_reg_set_nzcv <= 1'b0;
            out_reg_nzcv <= '0;
            out_flush <= 1'b0;
        end else begin
            out_rs_done <= 1'b0;
            out_reg_should_commit <= 1'b0;
            out_flush <= 1'b0;

            if (in_fu_done && r_valid[in_fu_rob_index]) begin
                r_done[in_fu_rob_index] <= 1'b1;
                r_value[in_fu_rob_index] <= in_fu_value;
                r_nzcv[in_fu_rob_index] <= in_fu_nzcv;
            end

            if (w_commit) begin
                out_reg_should_commit <= 1'b1;
                out_reg_reg_index <= r_dst[r_head];
                out_reg_commit_value <= r_value[r_head];
                out_reg_commit_rob_index <= r_head;
                out_reg_set_nzcv <= r_set_nzcv[r_head];
                out_reg_nzcv <= r_nzcv[r_head];
                out_flush <= w_flush;
                r_valid[r_head] <= 1'b0;
            end

            // A flushing commit empties the buffer and drops any dispatch on the same edge.
            if (w_flush) begin
                r_head <= '0;
                r_tail <= '0;
                r_count <= '0;
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    r_valid[i] <= 1'b0;
                    r_done[i] <= 1'b0;
                end
            end else begin
                if (w_dispatch) begin
                    r_valid[r_tail] <= 1'b1;
                    r_done[r_tail] <= 1'b0;
                    r_dst[r_tail] <= in_reg_dst;
                    r_set_nzcv[r_tail] <= in_reg_set_nzcv;
                    r_mispredict[r_tail] <= in_reg_mispredict;
                    r_tail <= r_tail + 1'b1;
                    out_rs_done <= 1'b1;
                    out_rs_rob_index <= r_tail;
                    out_rs_src1_valid <= w_src1[GPR_SIZE];
                    out_rs_src1_value <= w_src1[GPR_SIZE-1:0];
                    out_rs_src1_rob_index <= in_reg_src1_rob_index;
                    out_rs_src2_valid <= w_src2[GPR_SIZE];
                    out_rs_src2_value <= w_src2[GPR_SIZE-1:0];
                    out_rs_src2_rob_index <= in_reg_src2_rob_index;
                    out_rs_nzcv_valid <= w_nzcv[4];
                    out_rs_nzcv <= w_nzcv[3:0];
                    out_rs_nzcv_rob_index <= in_reg_nzcv_rob_index;
                    out_rs_fu_id <= in_reg_fu_id;
                    out_rs_fu_op <= in_reg_fu_op;
                    out_rs_cond_codes <= in_reg_cond_codes;
                    out_rs_set_nzcv <= in_reg_set_nzcv;
                    out_rs_uses_nzcv <= in_reg_uses_nzcv;
                end
                if (w_commit) r_head <= r_head + 1'b1;
                r_count <= r_count + CW'(w_dispatch) - CW'(w_commit);
            end
        end
    end
endmodule

// File: tb/tb_rob_module.sv
// Directed bench for rob_module: operand-resolution vector table plus hand-written sequences
// for in-order commit, full/wrap, mispredict flush and mid-operation reset.
module tb_rob_module;
    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_reg_done;
    logic [4:0]  in_reg_dst;
    logic        in_reg_set_nzcv, in_reg_uses_nzcv, in_reg_mispredict;
    logic        in_reg_src1_valid, in_reg_src2_valid, in_reg_nzcv_valid;
    logic [3:0]  in_reg_src1_rob_index, in_reg_src2_rob_index, in_reg_nzcv_rob_index;
    logic [63:0] in_reg_src1_value, in_reg_src2_value;
    logic [3:0]  in_reg_nzcv;
    logic [2:0]  in_reg_fu_id;
    logic [3:0]  in_reg_fu_op, in_reg_cond_codes;
    logic [3:0]  out_reg_next_rob_index;
    logic        out_full;
    logic        in_fu_done;
    logic [3:0]  in_fu_rob_index;
    logic [63:0] in_fu_value;
    logic [3:0]  in_fu_nzcv;
    logic        out_rs_done, out_rs_src1_valid, out_rs_src2_valid, out_rs_nzcv_valid;
    logic [63:0] out_rs_src1_value, out_rs_src2_value;
    logic [3:0]  out_rs_src1_rob_index, out_rs_src2_rob_index, out_rs_nzcv_rob_index;
    logic [3:0]  out_rs_nzcv, out_rs_rob_index, out_rs_fu_op, out_rs_cond_codes;
    logic [2:0]  out_rs_fu_id;
    logic        out_rs_set_nzcv, out_rs_uses_nzcv;
    logic        out_reg_should_commit, out_reg_set_nzcv, out_flush;
    logic [4:0]  out_reg_reg_index;
    logic [63:0] out_reg_commit_value;
    logic [3:0]  out_reg_commit_rob_index, out_reg_nzcv;

    int total = 0;
    int bad = 0;
    logic [63:0] exp_q[$];

    rob_module dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_reg_done(in_reg_done), .in_reg_dst(in_reg_dst),
        .in_reg_set_nzcv(in_reg_set_nzcv), .in_reg_uses_nzcv(in_reg_uses_nzcv),
        .in_reg_mispredict(in_reg_mispredict),
        .in_reg_src1_valid(in_reg_src1_valid), .in_reg_src1_rob_index(in_reg_src1_rob_index),
        .in_reg_src1_value(in_reg_src1_value),
        .in_reg_src2_valid(in_reg_src2_valid), .in_reg_src2_rob_index(in_reg_src2_rob_index),
        .in_reg_src2_value(in_reg_src2_value),
        .in_reg_nzcv_valid(in_reg_nzcv_valid), .in_reg_nzcv_rob_index(in_reg_nzcv_rob_index),
        .in_reg_nzcv(in_reg_nzcv), .in_reg_fu_id(in_reg_fu_id), .in_reg_fu_op(in_reg_fu_op),
        .in_reg_cond_codes(in_reg_cond_codes), .out_reg_next_rob_index(out_reg_next_rob_index),
        .out_full(out_full), .in_fu_done(in_fu_done), .in_fu_rob_index(in_fu_rob_index),
        .in_fu_value(in_fu_value), .in_fu_nzcv(in_fu_nzcv), .out_rs_done(out_rs_done),
        .out_rs_src1_valid(out_rs_src1_valid), .out_rs_src1_value(out_rs_src1_value),
        .out_rs_src1_rob_index(out_rs_src1_rob_index),
        .out_rs_src2_valid(out_rs_src2_valid), .out_rs_src2_value(out_rs_src2_value),
        .out_rs_src2_rob_index(out_rs_src2_rob_index),
        .out_rs_nzcv_valid(out_rs_nzcv_valid), .out_rs_nzcv(out_rs_nzcv),
        .out_rs_nzcv_rob_index(out_rs_nzcv_rob_index), .out_rs_rob_index(out_rs_rob_index),
        .out_rs_fu_id(out_rs_fu_id), .out_rs_fu_op(out_rs_fu_op),
        .out_rs_cond_codes(out_rs_cond_codes), .out_rs_set_nzcv(out_rs_set_nzcv),
        .out_rs_uses_nzcv(out_rs_uses_nzcv), .out_reg_should_commit(out_reg_should_commit),
        .out_reg_reg_index(out_reg_reg_index), .out_reg_commit_value(out_reg_commit_value),
        .out_reg_commit_rob_index(out_reg_commit_rob_index), .out_reg_set_nzcv(out_reg_set_nzcv),
        .out_reg_nzcv(out_reg_nzcv), .out_flush(out_flush)
    );

    // clock / reset
    always #5 in_clk = ~in_clk;

    typedef struct {
        logic        disp;
        logic        s1v;  logic [3:0] s1i; logic [63:0] s1val;
        logic        s2v;  logic [3:0] s2i;
        logic        nv;   logic [3:0] ni;
        logic        fud;  logic [3:0] fui; logic [63:0] fuval; logic [3:0] funz;
        logic        e_rs; logic [3:0] e_idx;
        logic        e1v;  logic [63:0] e1val;
        logic        e2v;  logic [63:0] e2val;
        logic        env;  logic [3:0] enz;
        logic        e_cm; logic [3:0] e_ctag; logic [63:0] e_cval;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clr();
        in_reg_done = 0; in_reg_dst = 0; in_reg_set_nzcv = 0; in_reg_uses_nzcv = 0;
        in_reg_mispredict = 0;
        in_reg_src1_valid = 1; in_reg_src1_rob_index = 0; in_reg_src1_value = 0;
        in_reg_src2_valid = 1; in_reg_src2_rob_index = 0; in_reg_src2_value = 0;
        in_reg_nzcv_valid = 1; in_reg_nzcv_rob_index = 0; in_reg_nzcv = 0;
        in_reg_fu_id = 0; in_reg_fu_op = 0; in_reg_cond_codes = 0;
        in_fu_done = 0; in_fu_rob_index = 0; in_fu_value = 0; in_fu_nzcv = 0;
    endtask

    task automatic do_reset();
        clr();
        in_rst = 1;
        tick();
        in_rst = 0;
    endtask

    task automatic fu(input logic [3:0] tag, input logic [63:0] val, input logic [3:0] nz);
        in_fu_done = 1; in_fu_rob_index = tag; in_fu_value = val; in_fu_nzcv = nz;
    endtask

    task automatic chk_commit(input string name, input logic [3:0] tag);
        logic [63:0] e;
        e = exp_q.pop_front();
        chk({name, "_commit"}, out_reg_should_commit, 1'b1);
        chk({name, "_tag"}, out_reg_commit_rob_index, tag);
        chk({name, "_value"}, out_reg_commit_value, e);
    endtask

    initial begin
        //            disp s1v s1i s1val s2v s2i nv ni  fud fui fuval funz  e_rs e_idx e1v e1val e2v e2val env enz e_cm ctag cval
        vecs[0] = '{1, 0, 0, 0,  1, 0, 1, 0,  0, 0, 0,  0,    1, 1, 0, 0,  1, 0,  1, 0,   0, 0, 0};
        vecs[1] = '{1, 0, 0, 0,  1, 0, 0, 0,  1, 0, 42, 4'hA, 1, 2, 1, 42, 1, 0,  1, 4'hA, 0, 0, 0};
        vecs[2] = '{1, 0, 0, 0,  1, 0, 1, 0,  0, 0, 0,  0,    1, 3, 1, 42, 1, 0,  1, 0,   1, 0, 42};
        vecs[3] = '{1, 1, 0, 7,  0, 1, 1, 0,  1, 2, 99, 4'h5, 1, 4, 1, 7,  0, 0,  1, 0,   0, 0, 0};
        vecs[4] = '{1, 1, 0, 0,  0, 2, 0, 2,  0, 0, 0,  0,    1, 5, 1, 0,  1, 99, 1, 4'h5, 0, 0, 0};
        vecs[5] = '{0, 1, 0, 0,  1, 0, 1, 0,  1, 1, 11, 0,    0, 0, 0, 0,  0, 0,  0, 0,   0, 0, 0};
        vecs[6] = '{0, 1, 0, 0,  1, 0, 1, 0,  0, 0, 0,  0,    0, 0, 0, 0,  0, 0,  0, 0,   1, 1, 11};
        vecs[7] = '{0, 1, 0, 0,  1, 0, 1, 0,  0, 0, 0,  0,    0, 0, 0, 0,  0, 0,  0, 0,   1, 2, 99};

        // reset state
        do_reset();
        chk("rst_full", out_full, 0);
        chk("rst_next_idx", out_reg_next_rob_index, 0);
        chk("rst_rs_done", out_rs_done, 0);
        chk("rst_commit", out_reg_should_commit, 0);
        chk("rst_flush", out_flush, 0);

        // first dispatch: X1 with architectural src1 = 5
        in_reg_done = 1; in_reg_dst = 1; in_reg_src1_value = 5; in_reg_set_nzcv = 1;
        in_reg_uses_nzcv = 1; in_reg_fu_id = 3'd2; in_reg_fu_op = 4'd5; in_reg_cond_codes = 4'd9;
        tick();
        clr();
        chk("d0_rs_done", out_rs_done, 1);
        chk("d0_src1_valid", out_rs_src1_valid, 1);
        chk("d0_src1_value", out_rs_src1_value, 5);
        chk("d0_rob_index", out_rs_rob_index, 0);
        chk("d0_next_idx", out_reg_next_rob_index, 1);
        chk("d0_fwd", {out_rs_fu_id, out_rs_fu_op, out_rs_cond_codes, out_rs_set_nzcv, out_rs_uses_nzcv},
            {3'd2, 4'd5, 4'd9, 1'b1, 1'b1});

        // operand resolution / commit table
        for (int i = 0; i < 8; i++) begin
            clr();
            in_reg_done = vecs[i].disp; in_reg_dst = 5'(i + 2);
            in_reg_src1_valid = vecs[i].s1v; in_reg_src1_rob_index = vecs[i].s1i;
            in_reg_src1_value = vecs[i].s1val;
            in_reg_src2_valid = vecs[i].s2v; in_reg_src2_rob_index = vecs[i].s2i;
            in_reg_nzcv_valid = vecs[i].nv; in_reg_nzcv_rob_index = vecs[i].ni;
            in_fu_done = vecs[i].fud; in_fu_rob_index = vecs[i].fui;
            in_fu_value = vecs[i].fuval; in_fu_nzcv = vecs[i].funz;
            tick();
            chk($sformatf("v%0d_rs_done", i), out_rs_done, vecs[i].e_rs);
            if (vecs[i].e_rs) begin
                chk($sformatf("v%0d_rs_idx", i), out_rs_rob_index, vecs[i].e_idx);
                chk($sformatf("v%0d_s1", i), {out_rs_src1_valid, out_rs_src1_value}, {vecs[i].e1v, vecs[i].e1val});
                chk($sformatf("v%0d_s1_tag", i), out_rs_src1_rob_index, vecs[i].s1i);
                chk($sformatf("v%0d_s2", i), {out_rs_src2_valid, out_rs_src2_value}, {vecs[i].e2v, vecs[i].e2val});
                chk($sformatf("v%0d_nz", i), {out_rs_nzcv_valid, out_rs_nzcv}, {vecs[i].env, vecs[i].enz});
            end
            chk($sformatf("v%0d_commit", i), out_reg_should_commit, vecs[i].e_cm);
            if (vecs[i].e_cm) begin
                chk($sformatf("v%0d_ctag", i), out_reg_commit_rob_index, vecs[i].e_ctag);
                chk($sformatf("v%0d_cval", i), out_reg_commit_value, vecs[i].e_cval);
            end
        end

        // out-of-order completion, in-order commit
        do_reset();
        in_reg_done = 1; in_reg_dst = 5'd7; in_reg_set_nzcv = 1; tick();
        in_reg_dst = 5'd8; in_reg_set_nzcv = 0; tick();
        clr(); fu(4'd1, 64'h22, 4'h3); tick();
        clr(); chk("ooo_no_commit_a", out_reg_should_commit, 0);
        tick(); chk("ooo_no_commit_b", out_reg_should_commit, 0);
        fu(4'd0, 64'h11, 4'hC); exp_q.push_back(64'h11); exp_q.push_back(64'h22);
        tick(); clr(); chk("ooo_no_commit_c", out_reg_should_commit, 0);
        tick(); chk_commit("ooo_c0", 4'd0);
        chk("ooo_c0_dst", out_reg_reg_index, 7);
        chk("ooo_c0_nzcv", {out_reg_set_nzcv, out_reg_nzcv}, {1'b1, 4'hC});
        tick(); chk_commit("ooo_c1", 4'd1);
        chk("ooo_c1_dst", out_reg_reg_index, 8);
        tick(); chk("ooo_idle", out_reg_should_commit, 0);

        // fill, refuse when full, wrap
        do_reset();
        in_reg_done = 1;
        for (int i = 0; i < 16; i++) tick();
        chk("full_set", out_full, 1);
        chk("full_next_wrap", out_reg_next_rob_index, 0);
        tick();
        chk("full_refuse_rs", out_rs_done, 0);
        chk("full_still", out_full, 1);
        in_reg_done = 0; fu(4'd0, 64'h77, 4'h0); tick();
        clr(); chk("full_no_commit_yet", out_reg_should_commit, 0);
        in_reg_done = 1; exp_q.push_back(64'h77); tick();
        chk_commit("full_c0", 4'd0);
        chk("full_refused_same_cycle", out_rs_done, 0);
        chk("full_freed", out_full, 0);
        chk("full_free_next", out_reg_next_rob_index, 0);
        tick();
        chk("wrap_rs_done", out_rs_done, 1);
        chk("wrap_rs_idx", out_rs_rob_index, 0);
        chk("wrap_full_again", out_full, 1);
        chk("wrap_next", out_reg_next_rob_index, 1);

        // mispredict at tag3 with five entries live
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_reg_done = 1; in_reg_mispredict = (i == 3); tick();
        end
        clr(); fu(4'd3, 64'h33, 4'h0); tick();
        fu(4'd0, 64'h30, 4'h0); tick();
        chk("mp_no_commit", out_reg_should_commit, 0);
        fu(4'd1, 64'h31, 4'h0); exp_q.push_back(64'h30); tick();
        chk_commit("mp_c0", 4'd0);
        fu(4'd2, 64'h32, 4'h0); exp_q.push_back(64'h31); tick();
        chk_commit("mp_c1", 4'd1);
        clr(); exp_q.push_back(64'h32); tick();
        chk_commit("mp_c2", 4'd2);
        chk("mp_no_flush_yet", out_flush, 0);
        in_reg_done = 1; exp_q.push_back(64'h33); tick();
        chk_commit("mp_c3", 4'd3);
        chk("mp_flush", out_flush, 1);
        chk("mp_drop_dispatch", out_rs_done, 0);
        chk("mp_next_idx", out_reg_next_rob_index, 0);
        chk("mp_not_full", out_full, 0);
        clr(); fu(4'd4, 64'h44, 4'h0); tick();
        chk("mp_flush_pulse", out_flush, 0);
        clr(); tick();
        chk("mp_empty_no_commit", out_reg_should_commit, 0);
        in_reg_done = 1; tick(); clr();
        chk("mp_restart_idx", out_rs_rob_index, 0);
        chk("mp_restart_next", out_reg_next_rob_index, 1);

        // reset with four entries live and a commit pending
        do_reset();
        in_reg_done = 1; in_reg_src1_value = 64'h55;
        for (int i = 0; i < 4; i++) tick();
        clr(); fu(4'd0, 64'h99, 4'hF); tick();
        clr(); in_rst = 1; tick();
        chk("mrst_commit", out_reg_should_commit, 0);
        chk("mrst_cval", out_reg_commit_value, 0);
        chk("mrst_rs", {out_rs_done, out_rs_src1_valid, out_rs_src1_value}, 0);
        chk("mrst_next", out_reg_next_rob_index, 0);
        chk("mrst_flush", out_flush, 0);
        in_rst = 0; tick();
        chk("mrst_after_commit", out_reg_should_commit, 0);
        tick();
        chk("mrst_after_commit2", out_reg_should_commit, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
